// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arbiter
//  Description : Two-port (instruction fetch / load-store) arbiter in front
//                of a single fixed-latency memory. One transaction at a time:
//                grant in IDLE, MEM_LAT cycles of memory access, then one
//                response cycle carrying the captured read data (or store
//                acknowledge) to the winning requester.
//
//  Parameters  : XLEN    - address/data width
//                MEM_LAT - memory access cycles, 1..15
//
//  Ports       : clk, reset (async, active-high)
//                if_req/if_addr -> if_gnt/if_rvalid/if_rdata   fetch port
//                ls_req/ls_we/ls_addr/ls_wdata
//                               -> ls_gnt/ls_rvalid/ls_rdata   load/store port
//                mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata memory port
//                busy                                         transaction in flight
//
//  Config      : ROUND_ROBIN_EN - when defined, simultaneous requests
//                alternate between IF and LS (first tie after reset -> IF).
//                When undefined, LS always wins a tie.
//
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int XLEN    = 64,
    parameter int MEM_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    // fetch port
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic            if_gnt,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    // load/store port
    input  logic            ls_req,
    input  logic            ls_we,
    input  logic [XLEN-1:0] ls_addr,
    input  logic [XLEN-1:0] ls_wdata,
    output logic            ls_gnt,
    output logic            ls_rvalid,
    output logic [XLEN-1:0] ls_rdata,
    // memory port
    output logic            mem_en,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            busy
);

    // ------------------------------------------------------------------------
    // Parameter sanity: the latency counter is 4 bits wide.
    // ------------------------------------------------------------------------
    generate
        if ((MEM_LAT < 1) || (MEM_LAT > 15)) begin : g_mem_lat_check
            $error("mem_arbiter: MEM_LAT must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] c_last_cnt = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [3:0]        r_cnt;
    logic              r_owner_ls;   // 1: current/last transaction belongs to LS
    logic              r_we;
    logic [XLEN-1:0]   r_addr;
    logic [XLEN-1:0]   r_wdata;
    logic [XLEN-1:0]   r_rdata;

    logic              w_can_grant;
    logic              w_tie_to_ls;
    logic              w_if_gnt;
    logic              w_ls_gnt;
    logic              w_any_gnt;
    logic              w_cnt_done;

    // ------------------------------------------------------------------------
    // Arbitration. Grants are combinational from the requests and only
    // possible in IDLE; reset gates them directly so a request that is high
    // while reset is asserted never sees a grant pulse.
    // ------------------------------------------------------------------------
    assign w_can_grant = (r_state == ST_IDLE) && !reset;

`ifdef ROUND_ROBIN_EN
    // r_owner_ls holds the most recent winner, so a tie goes to the other
    // side. Its reset value (LS) makes the first tie after reset go to IF.
    assign w_tie_to_ls = !r_owner_ls;
`else
    // Fixed priority: LS always wins a tie; ownership only routes the
    // response and never influences arbitration.
    assign w_tie_to_ls = 1'b1;
`endif

    assign w_if_gnt  = w_can_grant && if_req && !(ls_req && w_tie_to_ls);
    assign w_ls_gnt  = w_can_grant && ls_req && !(if_req && !w_tie_to_ls);
    assign w_any_gnt = w_if_gnt || w_ls_gnt;

    assign w_cnt_done = (r_cnt == c_last_cnt);

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_any_gnt) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_cnt_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Latency counter: cleared on the grant edge (entry to ACCESS) and
    // saturating at its terminal value, so it cannot wrap inside a
    // transaction even for MEM_LAT = 15.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= 4'd0;
        end else if (w_any_gnt) begin
            r_cnt <= 4'd0;
        end else if ((r_state == ST_ACCESS) && !w_cnt_done) begin
            r_cnt <= r_cnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Request capture at the grant edge. A fetch never writes, so the write
    // enable latches as zero for an IF grant regardless of ls_we.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner_ls <= 1'b1;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
        end else if (w_any_gnt) begin
            r_owner_ls <= w_ls_gnt;
            r_we       <= w_ls_gnt && ls_we;
            r_addr     <= w_ls_gnt ? ls_addr : if_addr;
            r_wdata    <= w_ls_gnt ? ls_wdata : '0;
        end
    end

    // ------------------------------------------------------------------------
    // Read data capture on the final ACCESS cycle; presented in RESP.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rdata <= '0;
        end else if ((r_state == ST_ACCESS) && w_cnt_done) begin
            r_rdata <= mem_rdata;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. All qualifiers decode the state register, so an asynchronous
    // reset drops them in the same cycle it is asserted.
    // ------------------------------------------------------------------------
    assign if_gnt    = w_if_gnt;
    assign ls_gnt    = w_ls_gnt;

    assign mem_en    = (r_state == ST_ACCESS);
    assign mem_we    = (r_state == ST_ACCESS) && r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign busy      = (r_state != ST_IDLE);

    assign if_rvalid = (r_state == ST_RESP) && !r_owner_ls;
    assign ls_rvalid = (r_state == ST_RESP) && r_owner_ls;
    assign if_rdata  = r_rdata;
    assign ls_rdata  = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_mem_arbiter
//  Description : Self-checking bench for mem_arbiter. Instance A uses
//                MEM_LAT=2 (directed scenarios plus randomized traffic against
//                a transaction-level model); instance B uses MEM_LAT=15.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int XLEN  = 64;
    localparam int LAT   = 2;
    localparam int LAT_B = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;

    logic            if_req, if_gnt, if_rvalid;
    logic [XLEN-1:0] if_addr, if_rdata;
    logic            ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [XLEN-1:0] ls_addr, ls_wdata, ls_rdata;
    logic            mem_en, mem_we, busy;
    logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;

    logic            b_if_req, b_if_gnt, b_if_rvalid;
    logic [XLEN-1:0] b_if_addr, b_if_rdata;
    logic            b_ls_req, b_ls_we, b_ls_gnt, b_ls_rvalid;
    logic [XLEN-1:0] b_ls_addr, b_ls_wdata, b_ls_rdata;
    logic            b_mem_en, b_mem_we, b_busy;
    logic [XLEN-1:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_arbiter #(.XLEN(XLEN), .MEM_LAT(LAT)) u_dut_a (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_arbiter #(.XLEN(XLEN), .MEM_LAT(LAT_B)) u_dut_b (
        .clk(clk), .reset(reset),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
        .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
        .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
        .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata), .busy(b_busy)
    );

    int checks = 0;
    int passes = 0;

    // ------------------------------------------------------------------------
    // Transaction-level reference model. m_t counts cycles since the grant
    // of the transaction in flight (-1: none). Memory is enabled for
    // t = 1..LAT, data sampled at t = LAT, response at t = LAT+1.
    // ------------------------------------------------------------------------
    int              m_t;
    bit              m_ls, m_we, m_last_ls;
    logic [XLEN-1:0] m_addr, m_wdata, m_data;
    bit e_if_gnt, e_ls_gnt, e_mem_en, e_mem_we, e_busy, e_if_rvalid, e_ls_rvalid;

    task automatic model_reset();
        m_t = -1; m_ls = 1'b1; m_we = 1'b0; m_last_ls = 1'b1;
        m_addr = '0; m_wdata = '0; m_data = '0;
    endtask

    task automatic model_eval();
        int winner;  // 0 none, 1 IF, 2 LS
        if (reset) model_reset();
        winner = 0;
        if (m_t < 0 && !reset) begin
            if (if_req && ls_req) begin
`ifdef ROUND_ROBIN_EN
                winner = m_last_ls ? 1 : 2;
`else
                winner = 2;
`endif
            end else if (if_req) winner = 1;
            else if (ls_req)     winner = 2;
        end
        e_if_gnt    = (winner == 1);
        e_ls_gnt    = (winner == 2);
        e_mem_en    = (m_t >= 1) && (m_t <= LAT);
        e_mem_we    = e_mem_en && m_we;
        e_busy      = (m_t >= 1);
        e_if_rvalid = (m_t == LAT + 1) && !m_ls;
        e_ls_rvalid = (m_t == LAT + 1) && m_ls;
    endtask

    task automatic model_clock();
        if (reset) begin
            model_reset();
        end else if (m_t >= 1) begin
            if (m_t == LAT) m_data = mem_rdata;
            m_t = (m_t == LAT + 1) ? -1 : m_t + 1;
        end else if (e_if_gnt || e_ls_gnt) begin
            m_t       = 1;
            m_ls      = e_ls_gnt;
            m_last_ls = e_ls_gnt;
            m_we      = e_ls_gnt && ls_we;
            m_addr    = e_ls_gnt ? ls_addr : if_addr;
            m_wdata   = ls_wdata;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        if_req = 0; ls_req = 0; b_if_req = 0; b_ls_req = 0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        model_reset();
    endtask

    // ------------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1; if_req = 1'b1; ls_req = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({if_gnt, ls_gnt, busy, mem_en, mem_we, if_rvalid, ls_rvalid} !== 7'b0)
            $display("FAIL reset_ctrl got %b exp 0000000",
                     {if_gnt, ls_gnt, busy, mem_en, mem_we, if_rvalid, ls_rvalid});
        else passes++;
        checks++;
        if ({if_rdata, ls_rdata} !== '0)
            $display("FAIL reset_rdata got %h/%h exp 0", if_rdata, ls_rdata);
        else passes++;
        checks++;
        if ({b_if_gnt, b_busy, b_mem_en} !== 3'b0)
            $display("FAIL reset_b got %b exp 000", {b_if_gnt, b_busy, b_mem_en});
        else passes++;
        @(posedge clk); #1;
        if_req = 0; ls_req = 0; reset = 1'b0;
    endtask

    // fetch: grant c0, memory c1-2, response c3 carrying 0xDEAD
    task automatic test_fetch();
        logic [6:0] exp;
        do_reset();
        if_req = 1'b1; if_addr = 64'h10;
        for (int c = 0; c < 5; c++) begin
            mem_rdata = (c == 2) ? 64'hDEAD : 64'(c + 64'h100);
            @(negedge clk);
            exp = {c == 0, 1'b0, (c == 1 || c == 2), 1'b0, (c >= 1 && c <= 3), c == 3, 1'b0};
            checks++;
            if ({if_gnt, ls_gnt, mem_en, mem_we, busy, if_rvalid, ls_rvalid} !== exp)
                $display("FAIL fetch_ctrl c=%0d got %b exp %b", c,
                         {if_gnt, ls_gnt, mem_en, mem_we, busy, if_rvalid, ls_rvalid}, exp);
            else passes++;
            if (c == 1) begin
                checks++;
                if (mem_addr !== 64'h10)
                    $display("FAIL fetch_addr got %h exp 10", mem_addr);
                else passes++;
            end
            if (c == 3) begin
                checks++;
                if (if_rdata !== 64'hDEAD)
                    $display("FAIL fetch_rdata got %h exp dead", if_rdata);
                else passes++;
            end
            @(posedge clk); #1;
            if (c == 0) begin if_req = 1'b0; if_addr = 64'hBAD; end
        end
    endtask

    // store: memory written twice with latched address/data, LS ack only
    task automatic test_store();
        logic [6:0] exp;
        do_reset();
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 64'h40; ls_wdata = 64'h55;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            exp = {1'b0, c == 0, (c == 1 || c == 2), (c == 1 || c == 2),
                   (c >= 1 && c <= 3), 1'b0, c == 3};
            checks++;
            if ({if_gnt, ls_gnt, mem_en, mem_we, busy, if_rvalid, ls_rvalid} !== exp)
                $display("FAIL store_ctrl c=%0d got %b exp %b", c,
                         {if_gnt, ls_gnt, mem_en, mem_we, busy, if_rvalid, ls_rvalid}, exp);
            else passes++;
            if (c == 1 || c == 2) begin
                checks++;
                if ({mem_addr, mem_wdata} !== {64'h40, 64'h55})
                    $display("FAIL store_bus c=%0d got %h/%h exp 40/55", c, mem_addr, mem_wdata);
                else passes++;
            end
            @(posedge clk); #1;
            if (c == 0) begin ls_req = 0; ls_we = 0; ls_addr = 64'hBAD; ls_wdata = 64'hBAD; end
        end
    endtask

    // both requesting continuously: grants every LAT+2 cycles, order per policy
    task automatic test_arbitration();
        int winners[$];
        int gcycle[$];
        do_reset();
        if_req = 1; ls_req = 1; ls_we = 0; if_addr = 64'h1000; ls_addr = 64'h2000;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            checks++;
            if (if_gnt && ls_gnt) $display("FAIL arb_double c=%0d got 11 exp one-hot", c);
            else passes++;
            if (if_gnt) begin winners.push_back(1); gcycle.push_back(c); end
            if (ls_gnt) begin winners.push_back(2); gcycle.push_back(c); end
            @(posedge clk); #1;
        end
        if_req = 0; ls_req = 0;
        checks++;
        if (winners.size() != 4) $display("FAIL arb_count got %0d exp 4", winners.size());
        else passes++;
        for (int k = 0; k < winners.size() && k < 4; k++) begin
            int exp_w;
`ifdef ROUND_ROBIN_EN
            exp_w = (k % 2 == 0) ? 1 : 2;
`else
            exp_w = 2;
`endif
            checks++;
            if (winners[k] != exp_w || gcycle[k] != k * (LAT + 2))
                $display("FAIL arb_grant k=%0d got w%0d@%0d exp w%0d@%0d",
                         k, winners[k], gcycle[k], exp_w, k * (LAT + 2));
            else passes++;
        end
    endtask

    // reset in second ACCESS cycle: immediate drop, no rvalid, then fresh grant
    task automatic test_reset_abort();
        do_reset();
        if_req = 1; if_addr = 64'h20;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1) $display("FAIL abort_gnt got %b exp 1", if_gnt);
        else passes++;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++;
        if ({mem_en, busy} !== 2'b11) $display("FAIL abort_pre got %b exp 11", {mem_en, busy});
        else passes++;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({mem_en, busy, if_rvalid, if_gnt} !== 4'b0)
            $display("FAIL abort_drop got %b exp 0000", {mem_en, busy, if_rvalid, if_gnt});
        else passes++;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if ({if_gnt, ls_gnt, if_rvalid, ls_rvalid, busy} !== 5'b0)
                $display("FAIL abort_hold c=%0d got %b exp 00000", c,
                         {if_gnt, ls_gnt, if_rvalid, ls_rvalid, busy});
            else passes++;
        end
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (if_gnt !== 1'b1) $display("FAIL abort_regrant got %b exp 1", if_gnt);
        else passes++;
        @(posedge clk); #1 if_req = 0;
    endtask

    // randomized traffic against the model, with occasional resets
    task automatic test_random();
        bit got_if, got_ls;
        do_reset();
        got_if = 0; got_ls = 0;
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(0, 149) == 0);
            if (!if_req || got_if) begin
                if_req  = ($urandom_range(0, 2) != 0);
                if_addr = {$urandom, $urandom};
            end
            if (!ls_req || got_ls) begin
                ls_req   = ($urandom_range(0, 2) != 0);
                ls_we    = $urandom_range(0, 1);
                ls_addr  = {$urandom, $urandom};
                ls_wdata = {$urandom, $urandom};
            end
            mem_rdata = {$urandom, $urandom};
            @(negedge clk);
            model_eval();
            checks++;
            if ({if_gnt, ls_gnt, mem_en, mem_we, busy, if_rvalid, ls_rvalid} !==
                {e_if_gnt, e_ls_gnt, e_mem_en, e_mem_we, e_busy, e_if_rvalid, e_ls_rvalid})
                $display("FAIL rand_ctrl c=%0d got %b exp %b", c,
                         {if_gnt, ls_gnt, mem_en, mem_we, busy, if_rvalid, ls_rvalid},
                         {e_if_gnt, e_ls_gnt, e_mem_en, e_mem_we, e_busy, e_if_rvalid, e_ls_rvalid});
            else passes++;
            if (e_mem_en) begin
                checks++;
                if (mem_addr !== m_addr) $display("FAIL rand_addr c=%0d got %h exp %h", c, mem_addr, m_addr);
                else passes++;
            end
            if (e_mem_we) begin
                checks++;
                if (mem_wdata !== m_wdata) $display("FAIL rand_wdata c=%0d got %h exp %h", c, mem_wdata, m_wdata);
                else passes++;
            end
            if (e_if_rvalid) begin
                checks++;
                if (if_rdata !== m_data) $display("FAIL rand_if_rdata c=%0d got %h exp %h", c, if_rdata, m_data);
                else passes++;
            end
            if (e_ls_rvalid && !m_we) begin
                checks++;
                if (ls_rdata !== m_data) $display("FAIL rand_ls_rdata c=%0d got %h exp %h", c, ls_rdata, m_data);
                else passes++;
            end
            got_if = e_if_gnt;
            got_ls = e_ls_gnt;
            model_clock();
            @(posedge clk); #1;
        end
        reset = 0; if_req = 0; ls_req = 0;
    endtask

    // MEM_LAT=15: 15 enable cycles, response at grant+16
    task automatic test_lat15();
        int en_cnt, first_en, last_en, rv_cnt, rv_at;
        do_reset();
        en_cnt = 0; first_en = -1; last_en = -1; rv_cnt = 0; rv_at = -1;
        b_if_req = 1; b_if_addr = 64'h77;
        for (int c = 0; c < 20; c++) begin
            b_mem_rdata = 64'h1000 + 64'(c);
            @(negedge clk);
            if (c == 0) begin
                checks++;
                if (b_if_gnt !== 1'b1) $display("FAIL lat15_gnt got %b exp 1", b_if_gnt);
                else passes++;
            end
            if (b_mem_en) begin
                en_cnt++; last_en = c;
                if (first_en < 0) first_en = c;
            end
            if (b_if_rvalid) begin
                rv_cnt++; rv_at = c;
                checks++;
                if (b_if_rdata !== 64'h100F) $display("FAIL lat15_rdata got %h exp 100f", b_if_rdata);
                else passes++;
            end
            if (c == 18) begin
                checks++;
                if (b_busy !== 1'b0) $display("FAIL lat15_idle got %b exp 0", b_busy);
                else passes++;
            end
            @(posedge clk); #1;
            if (c == 0) b_if_req = 0;
        end
        checks++;
        if (en_cnt != LAT_B || first_en != 1 || last_en != LAT_B)
            $display("FAIL lat15_en got %0d cycles [%0d..%0d] exp 15 [1..15]", en_cnt, first_en, last_en);
        else passes++;
        checks++;
        if (rv_cnt != 1 || rv_at != LAT_B + 1)
            $display("FAIL lat15_rvalid got %0d@%0d exp 1@16", rv_cnt, rv_at);
        else passes++;
    endtask

    initial begin
        reset = 1'b1;
        if_req = 0; if_addr = '0; ls_req = 0; ls_we = 0; ls_addr = '0; ls_wdata = '0;
        mem_rdata = '0;
        b_if_req = 0; b_if_addr = '0; b_ls_req = 0; b_ls_we = 0; b_ls_addr = '0;
        b_ls_wdata = '0; b_mem_rdata = '0;
        model_reset();

        test_reset();
        test_fetch();
        test_store();
        test_arbitration();
        test_reset_abort();
        test_random();
        test_lat15();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
